// File: rtl/led_pattern_drv_if.sv
// Command channel and LED status between the control FSM (master) and the LED pattern driver (slave).
interface led_pattern_drv_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_mode;
  logic [3:0] cmd_count;
  logic       led;
  logic       busy;
  logic       done;

  modport master (
    output cmd_valid, cmd_mode, cmd_count,
    input  cmd_ready, led, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_count,
    output cmd_ready, led, busy, done
  );
endinterface

// File: rtl/led_pattern_drv.sv
// Drives one LED with off/on/slow blink/fast blink/burst patterns, timed by a 1 ms prescaler.
module led_pattern_drv #(
  parameter int CLK_FREQ_KHZ = 95000,
  parameter int SLOW_HALF_MS = 500,
  parameter int FAST_HALF_MS = 100,
  parameter int PULSE_MS     = 200
) (
  input logic clk,
  input logic rst,
  led_pattern_drv_if.slave bus
);

  localparam int PH_A   = (SLOW_HALF_MS > FAST_HALF_MS) ? SLOW_HALF_MS : FAST_HALF_MS;
  localparam int PH_MAX = (PH_A > PULSE_MS) ? PH_A : PULSE_MS;
  localparam int PH_W   = $clog2(PH_MAX) + 1;
  localparam int PS_W   = (CLK_FREQ_KHZ > 1) ? $clog2(CLK_FREQ_KHZ) : 1;

  typedef enum logic [2:0] {
    S_OFF,
    S_ON,
    S_BLINK,
    S_BURST_ON,
    S_BURST_OFF
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PS_W-1:0] presc;
  logic [PH_W-1:0] ms_cnt;
  logic [PH_W-1:0] half_len;
  logic [PH_W-1:0] phase_len;
  logic [3:0]      remaining;
  logic            blink_lvl;
  logic            blink_nxt;
  logic            accept;
  logic            tick;
  logic            timed;
  logic            phase_end;
  logic            led_nxt;
  logic            busy_nxt;
  logic            done_nxt;

  assign bus.cmd_ready = (state == S_OFF) || (state == S_ON) || (state == S_BLINK);
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign tick          = (presc == PS_W'(CLK_FREQ_KHZ - 1));
  assign timed         = (state == S_BLINK) || (state == S_BURST_ON) || (state == S_BURST_OFF);
  assign phase_len     = (state == S_BLINK) ? half_len : PH_W'(PULSE_MS);
  assign phase_end     = timed && tick && (ms_cnt == phase_len - PH_W'(1));

  // A fresh blink command always starts on the lit half.
  assign blink_nxt = accept ? 1'b1 : ((state == S_BLINK && phase_end) ? ~blink_lvl : blink_lvl);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_OFF;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      case (bus.cmd_mode)
        3'd1:       state_nxt = S_ON;
        3'd2, 3'd3: state_nxt = S_BLINK;
        3'd4:       state_nxt = (bus.cmd_count != 4'd0) ? S_BURST_ON : S_OFF;
        default:    state_nxt = S_OFF;
      endcase
    end else if (phase_end) begin
      case (state)
        S_BURST_ON:  state_nxt = S_BURST_OFF;
        S_BURST_OFF: state_nxt = (remaining == 4'd0) ? S_OFF : S_BURST_ON;
        default:     state_nxt = state;
      endcase
    end
  end

  always_comb begin
    led_nxt  = 1'b0;
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    case (state_nxt)
      S_ON:        led_nxt = 1'b1;
      S_BLINK:     led_nxt = blink_nxt;
      S_BURST_ON:  begin led_nxt = 1'b1; busy_nxt = 1'b1; end
      S_BURST_OFF: busy_nxt = 1'b1;
      default:     led_nxt = 1'b0;
    endcase
    if (accept && bus.cmd_mode == 3'd4 && bus.cmd_count == 4'd0) begin
      done_nxt = 1'b1;
    end else if (!accept && state == S_BURST_OFF && phase_end && remaining == 4'd0) begin
      done_nxt = 1'b1;
    end
  end

  // Acceptance restarts both timers so the first phase of any new pattern is full length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc     <= '0;
      ms_cnt    <= '0;
      half_len  <= '0;
      remaining <= '0;
      blink_lvl <= 1'b0;
    end else begin
      if (accept || tick) begin
        presc <= '0;
      end else begin
        presc <= presc + PS_W'(1);
      end

      if (accept || !timed || phase_end) begin
        ms_cnt <= '0;
      end else if (tick) begin
        ms_cnt <= ms_cnt + PH_W'(1);
      end

      if (accept && bus.cmd_mode == 3'd2) begin
        half_len <= PH_W'(SLOW_HALF_MS);
      end else if (accept && bus.cmd_mode == 3'd3) begin
        half_len <= PH_W'(FAST_HALF_MS);
      end

      if (accept && bus.cmd_mode == 3'd4) begin
        remaining <= bus.cmd_count;
      end else if (state == S_BURST_ON && phase_end) begin
        remaining <= remaining - 4'd1;
      end

      blink_lvl <= blink_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.led  <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.led  <= led_nxt;
      bus.busy <= busy_nxt;
      bus.done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_led_pattern_drv.sv
// Bench for led_pattern_drv: directed scenarios then random commands, checked against a time-since-command model.
module tb_led_pattern_drv;

  localparam int KHZ   = 4;
  localparam int SLOW  = 5;
  localparam int FAST  = 2;
  localparam int PULSE = 3;

  localparam int K_OFF   = 0;
  localparam int K_ON    = 1;
  localparam int K_BLINK = 2;
  localparam int K_BURST = 3;

  logic clk = 1'b0;
  logic rst;

  led_pattern_drv_if bus_if ();

  led_pattern_drv #(
    .CLK_FREQ_KHZ (KHZ),
    .SLOW_HALF_MS (SLOW),
    .FAST_HALF_MS (FAST),
    .PULSE_MS     (PULSE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Model: pattern kind plus cycles elapsed since the command was accepted.
  int m_kind;
  int m_t;
  int m_half;
  int m_n;
  bit m_done;

  task automatic checkOutput(input string tag, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s at %0t: got %b, expected %b", tag, $time, got, exp);
    end
  endtask

  function automatic logic exp_led();
    case (m_kind)
      K_ON:    return 1'b1;
      K_BLINK: return ((m_t / m_half) % 2) == 0;
      K_BURST: return ((m_t / (PULSE * KHZ)) % 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic checkAll();
    checkOutput("led",   bus_if.led,       exp_led());
    checkOutput("busy",  bus_if.busy,      m_kind == K_BURST);
    checkOutput("done",  bus_if.done,      m_done);
    checkOutput("ready", bus_if.cmd_ready, m_kind != K_BURST);
  endtask

  task automatic modelReset();
    m_kind = K_OFF;
    m_t    = 0;
    m_half = 1;
    m_n    = 0;
    m_done = 1'b0;
  endtask

  task automatic modelStep(input bit acc, input logic [2:0] mode, input logic [3:0] cnt);
    m_done = 1'b0;
    if (acc) begin
      m_t = 0;
      case (mode)
        3'd1: m_kind = K_ON;
        3'd2: begin m_kind = K_BLINK; m_half = SLOW * KHZ; end
        3'd3: begin m_kind = K_BLINK; m_half = FAST * KHZ; end
        3'd4: begin
          if (cnt == 4'd0) begin
            m_kind = K_OFF;
            m_done = 1'b1;
          end else begin
            m_kind = K_BURST;
            m_n    = int'(cnt);
          end
        end
        default: m_kind = K_OFF;
      endcase
    end else begin
      m_t++;
      if (m_kind == K_BURST && m_t == 2 * m_n * PULSE * KHZ) begin
        m_kind = K_OFF;
        m_done = 1'b1;
      end
    end
  endtask

  task automatic applyStimulus(input bit v, input logic [2:0] mode, input logic [3:0] cnt);
    bit acc;
    @(negedge clk);
    checkAll();
    bus_if.cmd_valid = v;
    bus_if.cmd_mode  = mode;
    bus_if.cmd_count = cnt;
    acc = v && (m_kind != K_BURST);
    @(posedge clk);
    modelStep(acc, mode, cnt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 3'd0, 4'd0);
  endtask

  task automatic hitReset();
    @(negedge clk);
    checkAll();
    bus_if.cmd_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_led",   bus_if.led,       1'b0);
    checkOutput("rst_busy",  bus_if.busy,      1'b0);
    checkOutput("rst_done",  bus_if.done,      1'b0);
    checkOutput("rst_ready", bus_if.cmd_ready, 1'b1);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    modelStep(1'b0, 3'd0, 4'd0);
  endtask

  initial begin
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_mode  = 3'd0;
    bus_if.cmd_count = 4'd0;
    rst = 1'b1;
    modelReset();
    #1;
    checkAll();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    modelStep(1'b0, 3'd0, 4'd0);

    idle(100);

    applyStimulus(1'b1, 3'd1, 4'd0);
    idle(19);
    applyStimulus(1'b1, 3'd0, 4'd0);
    idle(10);

    applyStimulus(1'b1, 3'd3, 4'd0);
    idle(27);
    applyStimulus(1'b1, 3'd2, 4'd0);
    idle(45);

    applyStimulus(1'b1, 3'd4, 4'd2);
    for (int i = 0; i < 60; i++) applyStimulus(1'b1, 3'd1, 4'd0);

    applyStimulus(1'b1, 3'd4, 4'd0);
    idle(3);
    applyStimulus(1'b1, 3'd1, 4'd0);
    idle(3);
    applyStimulus(1'b1, 3'd6, 4'd0);
    idle(3);

    applyStimulus(1'b1, 3'd4, 4'd5);
    idle(19);
    hitReset();
    idle(150);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        hitReset();
      end else begin
        applyStimulus($urandom_range(0, 11) == 0, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 3)));
      end
    end

    @(negedge clk);
    checkAll();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
